// File: rtl/switch_debounce_pkg.sv
// Package for the switch debouncer: default geometry and the per-group FSM
// state type built on the state codes from switch_debounce_defs.vh.
package switch_debounce_pkg;

`include "switch_debounce_defs.vh"

  localparam int DEF_GROUPS          = 8;
  localparam int DEF_GROUP_W         = 8;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 20000;

  typedef enum logic {
    ST_IDLE  = S_IDLE,
    ST_COUNT = S_COUNT
  } grp_state_e;

endpackage

// File: rtl/switch_debounce_defs.vh
// Shared definitions for the switch debouncer: group FSM state codes and the
// counter-width macro. Guarded so repeated inclusion is harmless.
`ifndef SWITCH_DEBOUNCE_DEFS_VH
`define SWITCH_DEBOUNCE_DEFS_VH

// Group FSM state encodings.
localparam logic S_IDLE  = 1'b0;
localparam logic S_COUNT = 1'b1;

// Width of a counter that must hold values up to and including `cycles`.
`define SWITCH_DEBOUNCE_CNT_W(cycles) $clog2((cycles) + 1)

`endif

// File: rtl/switch_debounce_group.sv
// One debounce group: watches the synchronised group value, tracks a candidate
// and how many consecutive samples it has been seen for, and commits it to the
// stable register (with a one-cycle change pulse) once it has held long enough.
`include "switch_debounce_defs.vh"

module switch_debounce_group
  import switch_debounce_pkg::*;
#(
  parameter int GROUP_W         = 8,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [GROUP_W-1:0] i_sample,
  output logic [GROUP_W-1:0] o_stable,
  output logic               o_changed
);

  localparam int CNT_W = `SWITCH_DEBOUNCE_CNT_W(DEBOUNCE_CYCLES);
  // Count value at which one more matching sample completes the window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  grp_state_e         r_state;
  logic [GROUP_W-1:0] r_cand;
  logic [CNT_W-1:0]   r_cnt;
  logic [GROUP_W-1:0] r_stable;
  logic               r_changed;

  grp_state_e         w_state;
  logic [GROUP_W-1:0] w_cand;
  logic [CNT_W-1:0]   w_cnt;
  logic [GROUP_W-1:0] w_stable;
  logic               w_changed;

  // Next-state logic: candidate tracking, counting and commit decision.
  always_comb begin
    w_state   = r_state;
    w_cand    = r_cand;
    w_cnt     = r_cnt;
    w_stable  = r_stable;
    w_changed = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_sample != r_stable) begin
          if (DEBOUNCE_CYCLES == 1) begin
            // A single sample is enough: accept the new value right away.
            w_stable  = i_sample;
            w_changed = 1'b1;
            w_state   = ST_IDLE;
          end else begin
            w_cand  = i_sample;
            w_cnt   = CNT_W'(1);
            w_state = ST_COUNT;
          end
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (i_sample == r_stable) begin
          // Bounced back to the accepted value: drop the candidate silently.
          w_state = ST_IDLE;
        end else if (i_sample != r_cand) begin
          // A different new value: restart the window on it.
          w_cand = i_sample;
          w_cnt  = CNT_W'(1);
        end else if (r_cnt == CNT_LAST) begin
          w_stable  = r_cand;
          w_changed = 1'b1;
          w_state   = ST_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State, candidate, counter and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cand    <= {GROUP_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_stable  <= {GROUP_W{1'b0}};
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cand    <= w_cand;
      r_cnt     <= w_cnt;
      r_stable  <= w_stable;
      r_changed <= w_changed;
    end
  end

  assign o_stable  = r_stable;
  assign o_changed = r_changed;

endmodule

// File: rtl/switch_debounce.sv
// Switch debouncer top: synchronises the raw DIP switch pins into Clk and
// debounces them in independent groups. Build option SWITCH_INVERT_EN inverts
// the pins before the synchroniser for active-low switches.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int GROUPS          = DEF_GROUPS,
  parameter int GROUP_W         = DEF_GROUP_W,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [GROUPS*GROUP_W-1:0] SwRaw,
  output logic [GROUPS*GROUP_W-1:0] SwStable,
  output logic [GROUPS-1:0]         ChangedMask
);

  localparam int W = GROUPS * GROUP_W;

  logic [W-1:0] w_raw;
  logic [W-1:0] r_sync [SYNC_STAGES];
  logic [W-1:0] w_s;

`ifdef SWITCH_INVERT_EN
  assign w_raw = ~SwRaw;
`else
  assign w_raw = SwRaw;
`endif

  // Multi-flop synchroniser on every switch bit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= {W{1'b0}};
      end
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    switch_debounce_group #(
      .GROUP_W        (GROUP_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_grp (
      .i_clk    (Clk),
      .i_rst_n  (Reset_n),
      .i_sample (w_s[g*GROUP_W +: GROUP_W]),
      .o_stable (SwStable[g*GROUP_W +: GROUP_W]),
      .o_changed(ChangedMask[g])
    );
  end

endmodule
